bcd_calendar_counter: RTL and testbench
=======================================

Name: bcd_calendar_counter

Overview:
Sequential BCD date counter (DD-MM-YYYY) that advances one day per `day_tick` pulse. It handles month lengths, leap years (Gregorian or Julian rule) and year wrap 9999→0000. A validated load interface presets the date. It sits downstream of the seconds/minutes/hours BCD chain and feeds display and alarm logic.

Parameters:
- GREGORIAN, 1, 1 = full Gregorian rule (÷4, except ÷100 unless ÷400); 0 = Julian rule (÷4 only).
- RESET_DAY, 8'h01, BCD day after reset.
- RESET_MONTH, 8'h01, BCD month after reset.
- RESET_YEAR, 16'h2000, BCD year after reset; must be a legal date, checked by elaboration assertion.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `day_tick` input 1: one-cycle pulse; advance date by one day.
- `load_valid` input 1: load request; data below held stable while high.
- `load_ready` output 1: high only in IDLE; load accepted when `load_valid` & `load_ready`.
- `load_day` input 8: BCD day, two digits.
- `load_month` input 8: BCD month.
- `load_year` input 16: BCD year, four digits.
- `day` output 8: current BCD day.
- `month` output 8: current BCD month.
- `year` output 16: current BCD year.
- `leap` output 1: current year is leap under selected rule.
- `year_wrap` output 1: one-cycle pulse on 31-12-9999 → 01-01-0000.
- `load_err` output 1: one-cycle pulse; rejected load.
- `tick_lost` output 1: one-cycle pulse; `day_tick` arrived while not IDLE.

Behaviour:
- Reset (async assert, sync release):
  - `day`/`month`/`year` = RESET_* values; `leap` = rule(RESET_YEAR).
  - `load_ready` = 1; `year_wrap`, `load_err`, `tick_lost` = 0; FSM = IDLE.
- FSM states: IDLE, CHECK, COMMIT.
- IDLE:
  - `day_tick` increments the date. Registered outputs update on the next edge (latency 1).
  - Handshake accept → latch load fields into shadow registers; go to CHECK. Accept has priority over a same-cycle `day_tick`, which is dropped and pulses `tick_lost`.
- CHECK, one cycle:
  - Every nibble must be ≤9, else error.
  - Month 01..12, else error.
  - Day 01..dim, where dim = days-in-month for shadow month and leap(shadow year), else error.
  - Valid → COMMIT. Invalid → `load_err` pulse next cycle, return to IDLE; current date unchanged.
- COMMIT, one cycle: copy shadow to `day`/`month`/`year`; `leap` = leap(shadow year); return to IDLE.
- `load_ready` = 0 in CHECK and COMMIT. `day_tick` in those states is dropped and pulses `tick_lost` next cycle.
- Increment rules:
  - day < dim → day+1 with BCD digit carry (09→10, 19→20, 29→30).
  - day == dim → day=01; month+1 (09→10) or, if month==12, month=01 and year+1.
  - Year +1 is a 4-digit BCD ripple; 9999→0000 pulses `year_wrap` in the same cycle the outputs change.
  - `leap` is registered and recomputed whenever `year` is written (increment or commit), same edge.
- dim table: Feb = 29 if leap else 28; Apr/Jun/Sep/Nov = 30; others = 31.
- Leap rule:
  - Units-and-tens value ÷4 (BCD: tens parity with units ∈{0,4,8} for even tens, {2,6} for odd tens).
  - GREGORIAN: if tens/units == 00, test thousands/hundreds ÷4 instead.
  - Year 0000 is leap in both modes.
- Reset mid-load: all state cleared, shadow discarded, no pulse.
- Outputs never hold an illegal date.

Decomposition:
- `calendar_pkg`:
  - typedef `bcd_digit_t` (logic[3:0]) and `bcd_pair_t` (logic[7:0]).
  - enum `cal_state_t` {IDLE, CHECK, COMMIT}.
  - Constant 12-entry BCD days-in-month table (Feb = 28).
  - Function `bcd_inc_pair`.
- Sub-module `bcd_leap_check` (parameter GREGORIAN; combinational, 16-bit BCD year in, leap out). Instantiated twice: current year and shadow year.

Test Plan:
- Reset then no ticks → 01-01-2000, `leap`=1, `load_ready`=1, all pulses 0.
- Load 28-02-1900 (GREGORIAN=1), one tick → 01-03-1900, `leap`=0. Same with GREGORIAN=0 → 29-02-1900, `leap`=1.
- Load 28-02-2024, two ticks → 29-02-2024 then 01-03-2024; 365 further ticks from 01-03-2024 → 01-03-2025, `leap`=0.
- Load 31-12-9999, tick → 01-01-0000, `year_wrap`=1 for one cycle, `leap`=1.
- Load 29-02-2023, also 31-04-2024 and 1A-01-2024 → `load_err` pulse each; date unchanged; `load_ready` low exactly 1 cycle.
- `day_tick` held in accept cycle, CHECK and COMMIT → `tick_lost` three pulses; date equals loaded value. Assert `rst_n` during CHECK → outputs return to RESET_* values.

Source files
------------

// File: rtl/bcd_calendar_counter_pkg.sv
// Shared types, month-length table and BCD/date helper functions for the
// calendar counter.
package calendar_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [7:0] bcd_pair_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        COMMIT
    } cal_state_t;

    localparam bcd_pair_t DIM_TABLE [0:11] = '{
        8'h31, 8'h28, 8'h31, 8'h30, 8'h31, 8'h30,
        8'h31, 8'h31, 8'h30, 8'h31, 8'h30, 8'h31
    };

    function automatic bcd_pair_t bcd_inc_pair(input bcd_pair_t p);
        bcd_digit_t tens;
        bcd_digit_t units;
        tens  = p[7:4];
        units = p[3:0];
        if (units == 4'd9) begin
            units = 4'd0;
            tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            units = units + 4'd1;
        end
        return {tens, units};
    endfunction

    function automatic logic bcd_pair_valid(input bcd_pair_t p);
        return (p[7:4] <= 4'd9) && (p[3:0] <= 4'd9);
    endfunction

    // Divisibility by 4 of a two-digit BCD value: parity of tens selects units set
    function automatic logic bcd_div4(input bcd_pair_t p);
        if (p[4])
            return (p[3:0] == 4'd2) || (p[3:0] == 4'd6);
        return (p[3:0] == 4'd0) || (p[3:0] == 4'd4) || (p[3:0] == 4'd8);
    endfunction

    function automatic logic bcd_leap(input logic [15:0] y, input logic greg);
        if (greg && (y[7:0] == 8'h00))
            return bcd_div4(y[15:8]);
        return bcd_div4(y[7:0]);
    endfunction

    // Returns 00 for any month outside 01..12
    function automatic bcd_pair_t bcd_dim(input bcd_pair_t m, input logic lp);
        logic [4:0] idx;
        if (m[7:5] != 3'd0)
            return '0;
        idx = {1'b0, m[3:0]} + (m[4] ? 5'd10 : 5'd0);
        if ((idx == 5'd0) || (idx > 5'd12))
            return '0;
        if ((idx == 5'd2) && lp)
            return 8'h29;
        return DIM_TABLE[idx - 5'd1];
    endfunction

    function automatic logic bcd_date_legal(input bcd_pair_t d, input bcd_pair_t m,
                                            input logic [15:0] y, input logic greg);
        bcd_pair_t dim;
        if (!(bcd_pair_valid(d) && bcd_pair_valid(m) &&
              bcd_pair_valid(y[15:8]) && bcd_pair_valid(y[7:0])))
            return 1'b0;
        dim = bcd_dim(m, bcd_leap(y, greg));
        return (dim != 8'h00) && (d != 8'h00) && (d <= dim);
    endfunction

endpackage

// File: rtl/bcd_leap_check.sv
// Combinational leap-year test on a four-digit BCD year.
module bcd_leap_check
    import calendar_pkg::*;
#(
    parameter int unsigned GREGORIAN = 1
) (
    input  logic [15:0] year,
    output logic        leap
);

    always_comb begin
        leap = bcd_leap(year, GREGORIAN != 0);
    end

endmodule

// File: rtl/bcd_calendar_counter.sv
// BCD DD-MM-YYYY day counter with leap-year handling and a validated
// three-state load path (IDLE -> CHECK -> COMMIT).
module bcd_calendar_counter
    import calendar_pkg::*;
#(
    parameter int unsigned GREGORIAN   = 1,
    parameter logic [7:0]  RESET_DAY   = 8'h01,
    parameter logic [7:0]  RESET_MONTH = 8'h01,
    parameter logic [15:0] RESET_YEAR  = 16'h2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        day_tick,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [7:0]  load_day,
    input  logic [7:0]  load_month,
    input  logic [15:0] load_year,
    output logic [7:0]  day,
    output logic [7:0]  month,
    output logic [15:0] year,
    output logic        leap,
    output logic        year_wrap,
    output logic        load_err,
    output logic        tick_lost
);

    localparam logic GREG       = (GREGORIAN != 0);
    localparam logic RESET_LEAP = bcd_leap(RESET_YEAR, GREG);

    if (!bcd_date_legal(RESET_DAY, RESET_MONTH, RESET_YEAR, GREG)) begin : g_bad_reset_date
        $error("bcd_calendar_counter: RESET_DAY/MONTH/YEAR is not a legal date");
    end

    cal_state_t  state, state_nxt;
    bcd_pair_t   sh_day, sh_month;
    logic [15:0] sh_year;
    logic        sh_leap, sh_ok;
    bcd_pair_t   sh_dim, cur_dim;

    logic        accept, do_inc, do_commit, err_d, lost_d, wrap_d;
    bcd_pair_t   day_d, month_d;
    logic [15:0] year_d;
    logic        leap_d;

    // leap register follows whatever year is about to be written
    bcd_leap_check #(.GREGORIAN(GREGORIAN)) u_leap_next (
        .year (year_d),
        .leap (leap_d)
    );

    bcd_leap_check #(.GREGORIAN(GREGORIAN)) u_leap_shadow (
        .year (sh_year),
        .leap (sh_leap)
    );

    always_comb begin
        sh_dim = bcd_dim(sh_month, sh_leap);
        sh_ok  = bcd_pair_valid(sh_day) && bcd_pair_valid(sh_month) &&
                 bcd_pair_valid(sh_year[15:8]) && bcd_pair_valid(sh_year[7:0]) &&
                 (sh_dim != 8'h00) && (sh_day != 8'h00) && (sh_day <= sh_dim);
    end

    always_comb begin
        load_ready = (state == IDLE);
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        do_inc    = 1'b0;
        do_commit = 1'b0;
        err_d     = 1'b0;
        lost_d    = 1'b0;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    accept    = 1'b1;
                    lost_d    = day_tick;
                    state_nxt = CHECK;
                end else begin
                    do_inc = day_tick;
                end
            end
            CHECK: begin
                lost_d = day_tick;
                if (sh_ok) begin
                    state_nxt = COMMIT;
                end else begin
                    err_d     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            COMMIT: begin
                lost_d    = day_tick;
                do_commit = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cur_dim = bcd_dim(month, leap);
        day_d   = day;
        month_d = month;
        year_d  = year;
        wrap_d  = 1'b0;
        if (do_commit) begin
            day_d   = sh_day;
            month_d = sh_month;
            year_d  = sh_year;
        end else if (do_inc) begin
            if (day < cur_dim) begin
                day_d = bcd_inc_pair(day);
            end else begin
                day_d = 8'h01;
                if (month == 8'h12) begin
                    month_d = 8'h01;
                    year_d  = {(year[7:0] == 8'h99) ? bcd_inc_pair(year[15:8]) : year[15:8],
                               bcd_inc_pair(year[7:0])};
                    wrap_d  = (year == 16'h9999);
                end else begin
                    month_d = bcd_inc_pair(month);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day       <= RESET_DAY;
            month     <= RESET_MONTH;
            year      <= RESET_YEAR;
            leap      <= RESET_LEAP;
            year_wrap <= 1'b0;
            load_err  <= 1'b0;
            tick_lost <= 1'b0;
            sh_day    <= '0;
            sh_month  <= '0;
            sh_year   <= '0;
        end else begin
            day       <= day_d;
            month     <= month_d;
            year      <= year_d;
            leap      <= leap_d;
            year_wrap <= wrap_d;
            load_err  <= err_d;
            tick_lost <= lost_d;
            if (accept) begin
                sh_day   <= load_day;
                sh_month <= load_month;
                sh_year  <= load_year;
            end
        end
    end

endmodule

// File: tb/tb_bcd_calendar_counter.sv
// Self-checking bench: integer calendar model feeding an expectation queue,
// a table of load/tick vectors and hand-written handshake/reset sequences.
module tb_bcd_calendar_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        day_tick = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_day = '0;
    logic [7:0]  load_month = '0;
    logic [15:0] load_year = '0;

    logic        load_ready, leap, year_wrap, load_err, tick_lost;
    logic [7:0]  day, month;
    logic [15:0] year;
    logic        j_load_ready, j_leap, j_year_wrap, j_load_err, j_tick_lost;
    logic [7:0]  j_day, j_month;
    logic [15:0] j_year;

    bcd_calendar_counter dut (
        .clk(clk), .rst_n(rst_n), .day_tick(day_tick),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_day(load_day), .load_month(load_month), .load_year(load_year),
        .day(day), .month(month), .year(year), .leap(leap),
        .year_wrap(year_wrap), .load_err(load_err), .tick_lost(tick_lost)
    );

    bcd_calendar_counter #(.GREGORIAN(0)) dut_j (
        .clk(clk), .rst_n(rst_n), .day_tick(day_tick),
        .load_valid(load_valid), .load_ready(j_load_ready),
        .load_day(load_day), .load_month(load_month), .load_year(load_year),
        .day(j_day), .month(j_month), .year(j_year), .leap(j_leap),
        .year_wrap(j_year_wrap), .load_err(j_load_err), .tick_lost(j_tick_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic [7:0]  m;
        logic [15:0] y;
        logic        lp;
        logic        wr;
    } exp_t;

    typedef struct {
        logic [7:0]  ld;
        logic [7:0]  lm;
        logic [15:0] ly;
        int          nt;
        logic        err;
        logic [7:0]  ed;
        logic [7:0]  em;
        logic [15:0] ey;
        logic        el;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[13];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   md = 1, mm = 1, my = 2000;

    function automatic int bcd2i(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] i2bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic bit m_leap(input int y, input bit greg);
        if (greg)
            return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
        return (y % 4 == 0);
    endfunction

    function automatic int m_dim(input int m, input int y);
        if (m == 2) return m_leap(y, 1'b1) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model_date(input string nm);
        logic [15:0] b;
        b = i2bcd(md);
        check({nm, ".day"}, 32'(day), 32'(b[7:0]));
        b = i2bcd(mm);
        check({nm, ".month"}, 32'(month), 32'(b[7:0]));
        check({nm, ".year"}, 32'(year), 32'(i2bcd(my)));
        check({nm, ".leap"}, 32'(leap), 32'(m_leap(my, 1'b1)));
    endtask

    task automatic tick_once();
        exp_t        e;
        logic [15:0] b;
        int          oy;
        oy = my;
        e.wr = 1'b0;
        if (md < m_dim(mm, my)) begin
            md++;
        end else begin
            md = 1;
            if (mm == 12) begin
                mm = 1;
                my = (my + 1) % 10000;
                e.wr = (oy == 9999);
            end else begin
                mm++;
            end
        end
        b = i2bcd(md);    e.d = b[7:0];
        b = i2bcd(mm);    e.m = b[7:0];
        e.y  = i2bcd(my);
        e.lp = m_leap(my, 1'b1);
        sbq.push_back(e);
        day_tick = 1'b1;
        step();
        day_tick = 1'b0;
        e = sbq.pop_front();
        check("tick.day", 32'(day), 32'(e.d));
        check("tick.month", 32'(month), 32'(e.m));
        check("tick.year", 32'(year), 32'(e.y));
        check("tick.leap", 32'(leap), 32'(e.lp));
        check("tick.year_wrap", 32'(year_wrap), 32'(e.wr));
    endtask

    task automatic do_load(input logic [7:0] d, input logic [7:0] m, input logic [15:0] y,
                           input logic hold_tick, input logic exp_err);
        load_day   = d;
        load_month = m;
        load_year  = y;
        load_valid = 1'b1;
        day_tick   = hold_tick;
        check("load.ready_idle", 32'(load_ready), 32'd1);
        step();
        load_valid = 1'b0;
        check("load.ready_check", 32'(load_ready), 32'd0);
        if (hold_tick) check("load.lost_accept", 32'(tick_lost), 32'd1);
        step();
        if (exp_err) begin
            check("load.err_pulse", 32'(load_err), 32'd1);
            check("load.ready_back", 32'(load_ready), 32'd1);
            check_model_date("load.unchanged");
            day_tick = 1'b0;
            step();
            check("load.err_clear", 32'(load_err), 32'd0);
        end else begin
            check("load.no_err", 32'(load_err), 32'd0);
            check("load.ready_commit", 32'(load_ready), 32'd0);
            if (hold_tick) check("load.lost_check", 32'(tick_lost), 32'd1);
            step();
            day_tick = 1'b0;
            md = bcd2i({8'h00, d});
            mm = bcd2i({8'h00, m});
            my = bcd2i(y);
            check("load.ready_done", 32'(load_ready), 32'd1);
            if (hold_tick) check("load.lost_commit", 32'(tick_lost), 32'd1);
            check_model_date("load.committed");
        end
    endtask

    initial begin
        vecs[0]  = '{8'h28, 8'h02, 16'h2024, 2, 1'b0, 8'h01, 8'h03, 16'h2024, 1'b1};
        vecs[1]  = '{8'h31, 8'h12, 16'h9999, 1, 1'b0, 8'h01, 8'h01, 16'h0000, 1'b1};
        vecs[2]  = '{8'h29, 8'h02, 16'h2023, 0, 1'b1, 8'h00, 8'h00, 16'h0000, 1'b0};
        vecs[3]  = '{8'h31, 8'h04, 16'h2024, 0, 1'b1, 8'h00, 8'h00, 16'h0000, 1'b0};
        vecs[4]  = '{8'h1A, 8'h01, 16'h2024, 0, 1'b1, 8'h00, 8'h00, 16'h0000, 1'b0};
        vecs[5]  = '{8'h31, 8'h01, 16'h2019, 1, 1'b0, 8'h01, 8'h02, 16'h2019, 1'b0};
        vecs[6]  = '{8'h30, 8'h09, 16'h2023, 1, 1'b0, 8'h01, 8'h10, 16'h2023, 1'b0};
        vecs[7]  = '{8'h09, 8'h12, 16'h1999, 1, 1'b0, 8'h10, 8'h12, 16'h1999, 1'b0};
        vecs[8]  = '{8'h31, 8'h12, 16'h1999, 1, 1'b0, 8'h01, 8'h01, 16'h2000, 1'b1};
        vecs[9]  = '{8'h00, 8'h01, 16'h2000, 0, 1'b1, 8'h00, 8'h00, 16'h0000, 1'b0};
        vecs[10] = '{8'h01, 8'h13, 16'h2000, 0, 1'b1, 8'h00, 8'h00, 16'h0000, 1'b0};
        vecs[11] = '{8'h29, 8'h02, 16'h2000, 1, 1'b0, 8'h01, 8'h03, 16'h2000, 1'b1};
        vecs[12] = '{8'h19, 8'h07, 16'h2100, 1, 1'b0, 8'h20, 8'h07, 16'h2100, 1'b0};

        // reset state
        step();
        step();
        rst_n = 1'b1;
        step();
        check_model_date("reset");
        check("reset.day_lit", 32'(day), 32'h01);
        check("reset.year_lit", 32'(year), 32'h2000);
        check("reset.ready", 32'(load_ready), 32'd1);
        check("reset.wrap", 32'(year_wrap), 32'd0);
        check("reset.err", 32'(load_err), 32'd0);
        check("reset.lost", 32'(tick_lost), 32'd0);
        check("reset.j_leap", 32'(j_leap), 32'd1);

        // 1900: not leap under Gregorian, leap under Julian
        do_load(8'h28, 8'h02, 16'h1900, 1'b0, 1'b0);
        tick_once();
        check("julian.day", 32'(j_day), 32'h29);
        check("julian.month", 32'(j_month), 32'h02);
        check("julian.year", 32'(j_year), 32'h1900);
        check("julian.leap", 32'(j_leap), 32'd1);
        check("greg.day", 32'(day), 32'h01);
        check("greg.leap", 32'(leap), 32'd0);

        for (int i = 0; i < 13; i++) begin
            do_load(vecs[i].ld, vecs[i].lm, vecs[i].ly, 1'b0, vecs[i].err);
            if (!vecs[i].err) begin
                for (int k = 0; k < vecs[i].nt; k++) tick_once();
                check($sformatf("vec%0d.day", i), 32'(day), 32'(vecs[i].ed));
                check($sformatf("vec%0d.month", i), 32'(month), 32'(vecs[i].em));
                check($sformatf("vec%0d.year", i), 32'(year), 32'(vecs[i].ey));
                check($sformatf("vec%0d.leap", i), 32'(leap), 32'(vecs[i].el));
                step();
                check($sformatf("vec%0d.wrap_low", i), 32'(year_wrap), 32'd0);
            end
        end

        // a full year across a non-leap February
        do_load(8'h01, 8'h03, 16'h2024, 1'b0, 1'b0);
        for (int k = 0; k < 365; k++) tick_once();
        check("year.day", 32'(day), 32'h01);
        check("year.month", 32'(month), 32'h03);
        check("year.year", 32'(year), 32'h2025);
        check("year.leap", 32'(leap), 32'd0);

        // ticks held through accept, CHECK and COMMIT are all dropped
        do_load(8'h15, 8'h06, 16'h2010, 1'b1, 1'b0);
        check("hold.day", 32'(day), 32'h15);
        check("hold.year", 32'(year), 32'h2010);
        step();
        check("hold.lost_clear", 32'(tick_lost), 32'd0);

        // reset asserted while the load sits in CHECK
        load_day = 8'h10; load_month = 8'h10; load_year = 16'h2010;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        check("midrst.in_check", 32'(load_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        md = 1; mm = 1; my = 2000;
        check_model_date("midrst.async");
        check("midrst.ready", 32'(load_ready), 32'd1);
        check("midrst.err", 32'(load_err), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check_model_date("midrst.after");
        check("midrst.err_after", 32'(load_err), 32'd0);
        check("midrst.lost_after", 32'(tick_lost), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
